// File: rtl/writer_pkg.sv
// Shared types and helpers for the request writer.
package writer_pkg;

  // Width of the optional statistics counters.
  localparam int STAT_WIDTH = 32;

  // WAIT counts idle cycles; REQ holds a request until the arbiter grants it.
  typedef enum logic {
    WAIT = 1'b0,
    REQ  = 1'b1
  } state_t;

  // Bits needed to hold 0..max_count, never less than one bit.
  function automatic int counter_width(input int max_count);
    if (max_count < 1) begin
      return 1;
    end
    return $clog2(max_count + 1);
  endfunction

endpackage : writer_pkg

// File: rtl/req_writer_up_counter.sv
// Generic up counter with increment strobe, asynchronous active-low clear and
// optional saturation at all-ones (SATURATE=0 wraps).
module req_writer_up_counter #(
  parameter int WIDTH    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] count_reg;
  logic             at_limit;

  // Saturation only blocks the increment when the counter is configured to saturate.
  assign at_limit = SATURATE && (count_reg == {WIDTH{1'b1}});

  // Count on each strobe; cleared asynchronously by reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      count_reg <= '0;
    end else if (i_inc && !at_limit) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign o_count = count_reg;

endmodule : req_writer_up_counter

// File: rtl/req_writer.sv
// Traffic-generating client for the shared-FIFO bus arbiter.
// Idles COUNTER_MAX+1 cycles, then requests with a stable data word until the
// arbiter pulls i_busy low; the word then increments and the idle restarts.
// Optional feature macro: WRITER_STALL_STATS_EN adds stall/grant counters.
module req_writer
  import writer_pkg::*;
#(
  parameter int COUNTER_MAX = 3,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_busy,
  output logic                  o_req,
  output logic [DATA_WIDTH-1:0] o_data
`ifdef WRITER_STALL_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] o_stall_cycles,
  output logic [STAT_WIDTH-1:0] o_grants
`endif
);

  localparam int               CNT_W   = counter_width(COUNTER_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(COUNTER_MAX);

  state_t                  state_reg,   state_next;
  logic [CNT_W-1:0]        counter_reg, counter_next;
  logic                    req_reg,     req_next;
  logic [DATA_WIDTH-1:0]   data_reg,    data_next;

  // State, idle counter and both outputs are registered; reset may hit mid-request.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg   <= WAIT;
      counter_reg <= '0;
      req_reg     <= 1'b0;
      data_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
      req_reg     <= req_next;
      data_reg    <= data_next;
    end
  end

  // Next-state logic: busy is looked at only while requesting.
  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    req_next     = req_reg;
    data_next    = data_reg;
    case (state_reg)
      WAIT: begin
        if (counter_reg == CNT_MAX) begin
          counter_next = '0;
          req_next     = 1'b1;
          state_next   = REQ;
        end else begin
          counter_next = counter_reg + CNT_W'(1);
        end
      end
      REQ: begin
        if (!i_busy) begin
          // Grant: the word on the bus was accepted this cycle.
          req_next     = 1'b0;
          data_next    = data_reg + DATA_WIDTH'(1);
          counter_next = '0;
          state_next   = WAIT;
        end
      end
      default: begin
        state_next   = WAIT;
        counter_next = '0;
        req_next     = 1'b0;
      end
    endcase
  end

  assign o_req  = req_reg;
  assign o_data = data_reg;

`ifdef WRITER_STALL_STATS_EN
  logic stall_inc;
  logic grant_inc;

  // Strobes derived from the registered state, so they match the REQ edges exactly.
  assign stall_inc = (state_reg == REQ) && i_busy;
  assign grant_inc = (state_reg == REQ) && !i_busy;

  req_writer_up_counter #(
    .WIDTH    (STAT_WIDTH),
    .SATURATE (1'b1)
  ) u_stall_counter (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (stall_inc),
    .o_count (o_stall_cycles)
  );

  req_writer_up_counter #(
    .WIDTH    (STAT_WIDTH),
    .SATURATE (1'b0)
  ) u_grant_counter (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (grant_inc),
    .o_count (o_grants)
  );
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule : req_writer

// File: tb/tb_req_writer.sv
// Directed self-checking bench for req_writer (COUNTER_MAX=3 and COUNTER_MAX=0).
module tb_req_writer;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic       req;
  logic [7:0] data;

  logic       rst1_n;
  logic       busy1;
  logic       req1;
  logic [7:0] data1;

`ifdef WRITER_STALL_STATS_EN
  logic [31:0] stall_cycles, grants, stall_cycles1, grants1;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_data;

  req_writer #(.COUNTER_MAX(3), .DATA_WIDTH(8)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .i_busy  (busy),
    .o_req   (req),
    .o_data  (data)
`ifdef WRITER_STALL_STATS_EN
    ,
    .o_stall_cycles (stall_cycles),
    .o_grants       (grants)
`endif
  );

  req_writer #(.COUNTER_MAX(0), .DATA_WIDTH(8)) dut0 (
    .i_clk   (clk),
    .i_reset (rst1_n),
    .i_busy  (busy1),
    .o_req   (req1),
    .o_data  (data1)
`ifdef WRITER_STALL_STATS_EN
    ,
    .o_stall_cycles (stall_cycles1),
    .o_grants       (grants1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one rising edge and settle 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    rst1_n = 1'b0;
    busy   = 1'b1;
    busy1  = 1'b0;
    exp_data = 8'd0;
    tick();
    tick();
    check("reset_req", {31'd0, req}, 32'd0);
    check("reset_data", {24'd0, data}, 32'd0);

    // Release both resets between edges.
    rst_n  = 1'b1;
    rst1_n = 1'b1;

    // COUNTER_MAX=3: edges 1-3 idle, edge 4 requests. COUNTER_MAX=0 runs alongside
    // with busy held low: requests on odd edges, granted on even ones.
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("cm0_req_e%0d", k), {31'd0, req1}, 32'(k % 2));
      check($sformatf("cm0_data_e%0d", k), {24'd0, data1}, 32'(k / 2));
      if (k <= 3) check($sformatf("idle_req_e%0d", k), {31'd0, req}, 32'd0);
      else        check($sformatf("hold_req_e%0d", k), {31'd0, req}, 32'd1);
    end
    check("first_req_data", {24'd0, data}, 32'd0);

    // Hold busy high: request and word stay put.
    for (int k = 0; k < 20; k++) begin
      tick();
      check("stall_req", {31'd0, req}, 32'd1);
      check("stall_data", {24'd0, data}, 32'd0);
    end

    // One-cycle grant.
    busy = 1'b0;
    tick();
    busy = 1'b1;
    exp_data = 8'd1;
    check("grant_req", {31'd0, req}, 32'd0);
    check("grant_data", {24'd0, data}, {24'd0, exp_data});
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("regrant_req_e%0d", k), {31'd0, req}, (k == 4) ? 32'd1 : 32'd0);
    end
    check("rereq_data", {24'd0, data}, {24'd0, exp_data});

    // Asynchronous reset mid-request, between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_req", {31'd0, req}, 32'd0);
    check("async_rst_data", {24'd0, data}, 32'd0);
    tick();
    check("rst_hold_req", {31'd0, req}, 32'd0);
    rst_n = 1'b1;
    exp_data = 8'd0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("post_rst_req_e%0d", k), {31'd0, req}, (k == 4) ? 32'd1 : 32'd0);
    end
    // Five stalled REQ edges, then the grant.
    for (int k = 0; k < 5; k++) tick();
    check("stall5_req", {31'd0, req}, 32'd1);
    busy = 1'b0;
    tick();
    busy = 1'b1;
    exp_data = exp_data + 8'd1;
    check("stall5_grant_data", {24'd0, data}, {24'd0, exp_data});
`ifdef WRITER_STALL_STATS_EN
    check("stats_stall", stall_cycles, 32'd5);
    check("stats_grants", grants, 32'd1);
`endif

    // Busy low for three edges from REQ still accepts exactly once.
    for (int k = 1; k <= 4; k++) tick();
    check("long_low_pre_req", {31'd0, req}, 32'd1);
    busy = 1'b0;
    tick();
    tick();
    tick();
    busy = 1'b1;
    exp_data = exp_data + 8'd1;
    check("long_low_data", {24'd0, data}, {24'd0, exp_data});
    check("long_low_req", {31'd0, req}, 32'd0);
    // Two idle edges consumed already; two more reach the request.
    tick();
    check("long_low_idle_req", {31'd0, req}, 32'd0);
    tick();
    check("long_low_rereq", {31'd0, req}, 32'd1);

    // 256 grants with spurious busy-low pulses during WAIT; word wraps.
    for (int g = 0; g < 256; g++) begin
      busy = 1'b0;
      tick();
      busy = 1'b1;
      exp_data = exp_data + 8'd1;
      check($sformatf("wrap_g%0d_data", g), {24'd0, data}, {24'd0, exp_data});
      tick();
      busy = 1'b0;
      tick();
      busy = 1'b1;
      check($sformatf("wrap_g%0d_spurious", g), {23'd0, req, data}, {24'd0, exp_data});
      tick();
      tick();
      check($sformatf("wrap_g%0d_rereq", g), {31'd0, req}, 32'd1);
    end
    check("wrap_final_data", {24'd0, data}, {24'd0, exp_data});
`ifdef WRITER_STALL_STATS_EN
    check("stats_grants_total", grants, 32'd258);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_req_writer

// File: doc/req_writer.md
Name: req_writer

Overview:
- Traffic-generating client for the shared-FIFO bus arbiter.
- Waits a programmable idle period, then raises a write request and holds its data word stable until the arbiter grants access by pulling the busy line low.
- After a grant, advances its data word and restarts the idle period.
- One instance per arbiter request/busy lane.

Parameters:
- COUNTER_MAX, default 3: idle cycles counted (0..COUNTER_MAX) before each request; legal range ≥0.
- DATA_WIDTH, default 8: width of the data word presented to the bus.

Ports:
- i_clk, input, 1: single clock, rising edge.
- i_reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
- i_busy, input, 1: arbiter busy line. 1 = hold data and keep requesting; 0 = grant, data accepted this cycle.
- o_req, output, 1: write request to the arbiter.
- o_data, output, DATA_WIDTH: data word; valid and stable whenever o_req=1.

Behaviour:
- States (two-state FSM):
  - WAIT: idle counting.
  - REQ: requesting, waiting for grant.
- Idle counter:
  - Width max(1, $clog2(COUNTER_MAX+1)); unsigned; never exceeds COUNTER_MAX.
- Reset (i_reset=0, asynchronous, any time including mid-request):
  - state=WAIT, counter=0, o_req=0, o_data=0.
  - All outputs are registered, so no combinational path from i_busy to o_req.
- WAIT:
  - Each rising edge: if counter==COUNTER_MAX, then counter←0, o_req←1, state←REQ; else counter←counter+1.
  - First o_req rises on the (COUNTER_MAX+1)th rising edge after reset release.
  - COUNTER_MAX=0 requests on the first edge.
  - i_busy is ignored in WAIT; a spurious low has no effect.
- REQ:
  - o_req held 1 and o_data held constant while i_busy=1, indefinitely (no timeout).
  - Edge with i_busy=0 is the grant/accept:
    - o_req←0, o_data←o_data+1 (wraps modulo 2^DATA_WIDTH).
    - counter←0, state←WAIT.
- Consequences:
  - o_req deasserts the cycle after the one-cycle busy-low pulse.
  - Next request follows COUNTER_MAX+1 cycles later.
  - Minimum request-to-request spacing is COUNTER_MAX+2 cycles after a grant.
- Simultaneous events:
  - Reset overrides grant.
  - Grant is sampled only in REQ.
  - Busy low lasting more than one cycle still yields exactly one accept.

Optional Feature:
- Macro WRITER_STALL_STATS_EN.
- Defined:
  - Adds output o_stall_cycles (32 bits): count of edges spent in REQ with i_busy=1, saturating at all-ones.
  - Adds output o_grants (32 bits): count of accepts, wrapping.
  - Both cleared by reset.
- Undefined: ports and logic are absent; core behaviour is identical.

Decomposition:
- Package writer_pkg holds:
  - state enum {WAIT, REQ};
  - counter-width helper function;
  - STAT_WIDTH=32 constant.
- No sub-module required. An optional generic up_counter sub-module may implement both the idle counter and the stats counters.

Test Plan (COUNTER_MAX=3, DATA_WIDTH=8, unless noted):
- Reset release with i_busy held 1 → o_req=0 for edges 1–3, rises on edge 4 with o_data=0, then stays 1 for 20+ cycles with o_data constant.
- During REQ, drive i_busy=0 for one cycle → next edge o_req=0, o_data=1; o_req rises again 4 edges later.
- Assert i_reset=0 mid-request, asynchronously between edges → o_req and o_data go to 0 immediately; the idle count restarts after release.
- COUNTER_MAX=0 with i_busy grant every request → o_req toggles 1,0,1,0…, o_data increments each grant.
- Drive 256 grants → o_data wraps 255→0; i_busy low pulses during WAIT leave o_data unchanged.
- WRITER_STALL_STATS_EN defined, grant after 5 stalled REQ cycles → o_stall_cycles=5, o_grants=1.
